// File: rtl/apb_slave_pkg.sv
// ============================================================================
// Module   : apb_slave_pkg
// Brief    : Shared types and constants for the APB3 memory completer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int c_CNT_W = 4;

    // Wide enough for any practical DATA_W; users slice the low bits.
    localparam logic [63:0] c_PRDATA_RST = 64'h0;

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem_array.sv
// ============================================================================
// Module   : apb_slave_mem_array
// Brief    : MEM_DEPTH x DATA_W register storage, async clear, 1W/1R ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem_array
    import apb_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 128,
    parameter int IDX_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Callers only consume the read data for in-range addresses.
    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module   : apb_slave_mem
// Brief    : APB3 completer with byte register memory, wait states, PSLVERR.
//            APB_SLAVE_WPROT_EN makes [PROT_BASE, MEM_DEPTH) write-protected.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 128,
    parameter int WAIT_CYCLES = 0
`ifdef APB_SLAVE_WPROT_EN
    ,
    parameter int PROT_BASE   = MEM_DEPTH / 2
`endif
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int                 c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [c_CNT_W-1:0] c_WAIT  = c_CNT_W'(WAIT_CYCLES);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_write;
    logic                r_err;
    logic [c_IDX_W-1:0]  r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_prdata;

    logic                w_oor;
    logic                w_err;
    logic                w_ready;
    logic                w_done;
    logic                w_we;
    logic [DATA_W-1:0]   w_rdata;

    assign w_oor = ({1'b0, PADDR} >= c_DEPTH);

`ifdef APB_SLAVE_WPROT_EN
    localparam logic [ADDR_W:0] c_PROT = (ADDR_W + 1)'(PROT_BASE);
    assign w_err = w_oor | (PWRITE & ({1'b0, PADDR} >= c_PROT));
`else
    assign w_err = w_oor;
`endif

    // PREADY comes from registers only, so it cannot glitch on bus inputs.
    assign w_ready = (r_state == ACCESS) && (r_cnt == c_WAIT);
    assign w_done  = w_ready & PSEL & PENABLE;
    assign w_we    = w_done & r_write & ~r_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_prdata <= c_PRDATA_RST[DATA_W-1:0];
        end else if (r_state == IDLE) begin
            if (PSEL && !PENABLE) begin
                r_state  <= ACCESS;
                r_cnt    <= '0;
                r_write  <= PWRITE;
                r_err    <= w_err;
                r_waddr  <= PADDR[c_IDX_W-1:0];
                r_wdata  <= PWDATA;
                r_prdata <= (!PWRITE && !w_oor) ? w_rdata : c_PRDATA_RST[DATA_W-1:0];
            end
        end else begin
            if (!PSEL || w_done) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (r_cnt < c_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    apb_slave_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (c_IDX_W)
    ) u_array (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (r_wdata),
        .i_raddr (PADDR[c_IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign PREADY  = w_ready;
    assign PSLVERR = r_err & w_ready;
    assign PRDATA  = r_prdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// Module   : tb_apb_slave_mem
// Brief    : Scoreboard bench for apb_slave_mem, WAIT_CYCLES=0 and =3 instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

`ifdef APB_SLAVE_WPROT_EN
    localparam bit c_WPROT = 1'b1;
`else
    localparam bit c_WPROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel0, psel1, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       pready0, pslverr0, pready1, pslverr1;
    logic [7:0] prdata0, prdata1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model0 [128];
    logic [7:0] model1 [128];

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
    );

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(3)) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic cur_ready(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    function automatic logic cur_err(input int d);
        return (d == 0) ? pslverr0 : pslverr1;
    endfunction

    function automatic logic [7:0] cur_rdata(input int d);
        return (d == 0) ? prdata0 : prdata1;
    endfunction

    task automatic set_psel(input int d, input logic v);
        if (d == 0) psel0 = v;
        else        psel1 = v;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 128; i++) begin
            model0[i] = 8'h00;
            model1[i] = 8'h00;
        end
    endtask

    // Entered on a negedge; returns on the negedge after completion so a
    // following call presents its setup phase with no idle cycle.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        logic err;
        int   cyc;
        err     = (addr >= 8'd128) || (wr && c_WPROT && (addr >= 8'd64));
        e.err   = err;
        e.rdata = 8'h00;
        if (!wr && !err) e.rdata = (d == 0) ? model0[addr[6:0]] : model1[addr[6:0]];
        sb_q.push_back(e);
        if (wr && !err) begin
            if (d == 0) model0[addr[6:0]] = wdata;
            else        model1[addr[6:0]] = wdata;
        end
        set_psel(d, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge clk);
        penable = 1'b1;
        paddr   = ~addr;
        pwdata  = ~wdata;
        cyc = 0;
        while (!cur_ready(d) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("access_cycles", cyc + 1, (d == 0) ? 1 : 4);
        e = sb_q.pop_front();
        check("prdata", {24'h0, cur_rdata(d)}, {24'h0, e.rdata});
        check("pslverr", {31'h0, cur_err(d)}, {31'h0, e.err});
        @(negedge clk);
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        check("ready_after_done", {31'h0, cur_ready(d)}, 32'h0);
        check("pslverr_after_done", {31'h0, cur_err(d)}, 32'h0);
        if (!wr) check("prdata_hold", {24'h0, cur_rdata(d)}, {24'h0, e.rdata});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        clear_models();
        #1;
        check("rst_pready0", {31'h0, pready0}, 32'h0);
        check("rst_pslverr0", {31'h0, pslverr0}, 32'h0);
        check("rst_prdata1", {24'h0, prdata1}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray PENABLE in IDLE must not start a transfer.
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h05;
        @(negedge clk);
        check("stray_penable", {31'h0, pready0}, 32'h0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk);

        xfer(0, 1'b0, 8'h05, 8'h00);
        xfer(0, 1'b1, 8'h10, 8'hA5);
        xfer(0, 1'b0, 8'h10, 8'h00);

        xfer(1, 1'b1, 8'h7F, 8'h3C);
        xfer(1, 1'b0, 8'h7F, 8'h00);

        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 8'h80, 8'h55);
            xfer(d, 1'b0, 8'h80, 8'h00);
            xfer(d, 1'b0, 8'h00, 8'h00);
        end

        xfer(0, 1'b1, 8'h01, 8'h11);
        xfer(0, 1'b1, 8'h02, 8'h22);
        xfer(0, 1'b0, 8'h01, 8'h00);
        xfer(0, 1'b0, 8'h02, 8'h00);

        xfer(0, 1'b1, 8'h40, 8'h99);
        xfer(0, 1'b0, 8'h40, 8'h00);

        // Abort: PSEL dropped during the wait states of the WAIT_CYCLES=3 DUT.
        xfer(1, 1'b1, 8'h20, 8'h11);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h22;
        @(negedge clk);
        penable = 1'b1;
        check("abort_ready_a", {31'h0, pready1}, 32'h0);
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        check("abort_ready_b", {31'h0, pready1}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_ready", {31'h0, pready1}, 32'h0);
        end
        xfer(1, 1'b0, 8'h20, 8'h00);

        for (int i = 0; i < 24; i++) begin
            int         d;
            logic       wr;
            logic [7:0] a;
            logic [7:0] v;
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            v  = 8'($urandom_range(0, 255));
            xfer(d, wr, a, v);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        // Reset asserted mid-write; outputs clear immediately and write is lost.
        xfer(0, 1'b1, 8'h33, 8'hC3);
        xfer(0, 1'b0, 8'h33, 8'h00);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77;
        @(negedge clk);
        penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pready", {31'h0, pready0}, 32'h0);
        check("midrst_pslverr", {31'h0, pslverr0}, 32'h0);
        check("midrst_prdata", {24'h0, prdata0}, 32'h0);
        @(negedge clk);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_models();
        @(negedge clk);
        xfer(0, 1'b0, 8'h05, 8'h00);
        xfer(0, 1'b0, 8'h33, 8'h00);
        xfer(1, 1'b0, 8'h7F, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3 completer (responder) holding a byte-wide register memory. It is the far end of the APB master bridge, one instance per PSEL line.
- Decodes setup and access phases.
- Inserts a programmable number of wait states.
- Performs reads and writes on local storage.
- Flags out-of-range accesses with PSLVERR.

Parameters:
ADDR_W, 8, PADDR width in bits
DATA_W, 8, PWDATA/PRDATA width in bits
MEM_DEPTH, 128, number of implemented locations; any PADDR >= MEM_DEPTH is an error (must be <= 2**ADDR_W)
WAIT_CYCLES, 0, wait states inserted in every access phase (0..15)

Ports:
PCLK  input  1  bus clock; all state updates on posedge
PRESETn  input  1  asynchronous active-low reset
PSEL  input  1  slave select from master
PENABLE  input  1  access-phase strobe
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_W  byte address
PWDATA  input  DATA_W  write data
PREADY  output  1  transfer completes this cycle
PRDATA  output  DATA_W  read data, valid while PREADY=1 on a read
PSLVERR  output  1  error response, valid only while PREADY=1

Behaviour:
- Reset, PRESETn low, asynchronous: FSM=IDLE, wait counter=0, PRDATA=0, PSLVERR=0, PREADY=0, all memory locations=0.
- FSM states: IDLE, ACCESS.
- IDLE -> ACCESS on a posedge sampling PSEL=1, PENABLE=0 (setup phase). At that edge:
  - Latch PWRITE, PADDR and PWDATA.
  - Compute err = (PADDR >= MEM_DEPTH).
  - Load the counter with 0.
  - For a non-error read, capture mem[PADDR] into the PRDATA register. For an error read or any write, PRDATA=0.
- In ACCESS:
  - PREADY = (cnt == WAIT_CYCLES). It is decoded from registers only, so it is glitch-free.
  - The counter increments each cycle while below WAIT_CYCLES.
- Completion is a posedge with state=ACCESS, PSEL=1, PENABLE=1 and PREADY=1:
  - Non-error write: mem[addr] <= wdata.
  - Error write: no memory change.
  - State -> IDLE, counter -> 0.
- Latency: the setup cycle plus WAIT_CYCLES+1 access cycles. WAIT_CYCLES=0 gives the standard 2-cycle transfer.
- PSLVERR = err & PREADY. It is 0 at all other times.
- PRDATA holds its value after completion until the next setup edge.
- Back-to-back transfers: the master's new setup phase in the cycle after completion is sampled in IDLE with no lost cycle.
- Protocol violations:
  - PSEL deasserted while in ACCESS: abort to IDLE, no memory write, no PREADY pulse.
  - PENABLE=1 seen in IDLE without a prior setup: ignored, stays IDLE.
- Address and data changes during ACCESS are ignored; the latched setup values are used.
- Reset asserted mid-transfer: immediate return to reset values, and the pending write is dropped.

Optional Feature:
Macro APB_SLAVE_WPROT_EN.
- When defined:
  - Adds parameter PROT_BASE (default MEM_DEPTH/2).
  - Writes to PROT_BASE <= addr < MEM_DEPTH are treated as errors: PSLVERR=1 at completion and memory unchanged.
  - Reads of that region are unaffected, so it acts as a read-only region.
- When undefined: no protection; only the out-of-range error exists.

Decomposition:
- Shared package apb_slave_pkg:
  - State typedef: enum logic {IDLE, ACCESS}.
  - Wait-counter width constant (4 bits).
  - Reset-value constant for PRDATA.
- One natural sub-module, apb_slave_mem_array: storage of MEM_DEPTH x DATA_W with async clear, one write port and one read port.
- The FSM, counter and error logic stay in apb_slave_mem.

Test Plan:
- Reset: PRESETn=0 mid-stream -> PREADY=0, PSLVERR=0, PRDATA=0 immediately; a read of addr 0x05 after reset returns 0x00.
- Write then read, WAIT_CYCLES=0: write 0xA5 to 0x10, then read 0x10 -> PREADY high in the first access cycle, PRDATA=0xA5, PSLVERR=0; each transfer takes 2 cycles.
- Wait states, WAIT_CYCLES=3: write 0x3C to 0x7F -> PREADY low for 3 access cycles and high on the 4th; read-back returns 0x3C.
- Out of range: write 0x55 to 0x80, then read 0x80 -> PSLVERR=1 with PREADY on both; read PRDATA=0x00; memory unchanged.
- Back-to-back and abort: consecutive writes to 0x01 and 0x02 with no idle -> both committed. A transfer with PSEL dropped mid-ACCESS -> no PREADY, target byte unchanged.
- APB_SLAVE_WPROT_EN with PROT_BASE=0x40: write 0x99 to 0x40 -> PSLVERR=1; read 0x40 returns the prior value 0x00 with PSLVERR=0.
